// File: rtl/gb_bank_scheduler_pkg.sv
// Shared definitions for the global-buffer bank scheduler: FSM encodings
// and the bank-ID width rule.
package gb_bank_scheduler_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PREP = 2'd1,
    R_GAP  = 2'd2
  } rd_state_e;

  localparam int GB_NUM_BANK_DEF = 4;

  // A ring of two banks still needs one ID bit.
  function automatic int bank_id_w(input int num_bank);
    return (num_bank <= 2) ? 1 : $clog2(num_bank);
  endfunction

endpackage

// File: rtl/gb_bank_ring_ptr.sv
// Write/read pointers and occupancy count for the bank ring; clr wipes the
// ring and dominates any push or pop in the same cycle.
module gb_bank_ring_ptr
  import gb_bank_scheduler_pkg::*;
#(
  parameter int NUM_BANK = GB_NUM_BANK_DEF,
  parameter int ID_W     = bank_id_w(NUM_BANK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  output logic [ID_W-1:0] wp,
  output logic [ID_W-1:0] rp,
  output logic [ID_W:0]   full_cnt,
  output logic            full,
  output logic            empty
);

  logic [ID_W-1:0] wp_q, wp_d;
  logic [ID_W-1:0] rp_q, rp_d;
  logic [ID_W:0]   cnt_q, cnt_d;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + ID_W'(1);
      if (pop)  rp_d = rp_q + ID_W'(1);
      if (push && !pop)      cnt_d = cnt_q + (ID_W+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (ID_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign wp       = wp_q;
  assign rp       = rp_q;
  assign full_cnt = cnt_q;
  assign full     = (cnt_q == (ID_W+1)'(NUM_BANK));
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/gb_bank_scheduler.sv
// Hands free global-buffer banks to the fill side, feeds filled banks to the
// reader in FIFO order, and counts retired bank reads per layer.
module gb_bank_scheduler
  import gb_bank_scheduler_pkg::*;
#(
  parameter int NUM_BANK     = GB_NUM_BANK_DEF,
  parameter int ID_W         = bank_id_w(NUM_BANK),
  parameter int CYC_BITWIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CYC_BITWIDTH-1:0] cyc_num,
  input  logic                    wr_req,
  output logic                    wr_grant,
  output logic [ID_W-1:0]         wr_bank_id,
  input  logic                    wr_done,
  output logic                    rd_prepare,
  output logic [ID_W-1:0]         rd_bank_id,
  input  logic                    rd_done,
  input  logic                    pull_back,
  output logic [ID_W:0]           full_cnt,
  output logic [CYC_BITWIDTH-1:0] cyc,
  output logic                    all_done
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic                    gap_q, gap_d;
  logic [ID_W-1:0]         rd_bank_id_q, rd_bank_id_d;
  logic                    rd_prepare_q, rd_prepare_d;
  logic [CYC_BITWIDTH-1:0] cyc_q, cyc_d;
  logic                    all_done_q, all_done_d;

  logic                    push, pop;
  logic [ID_W-1:0]         wp, rp;
  logic                    full, empty;
  logic [CYC_BITWIDTH-1:0] last_cyc;
  logic                    last_read;

  gb_bank_ring_ptr #(
    .NUM_BANK (NUM_BANK),
    .ID_W     (ID_W)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .push     (push),
    .pop      (pop),
    .wp       (wp),
    .rp       (rp),
    .full_cnt (full_cnt),
    .full     (full),
    .empty    (empty)
  );

  // Write side: grant is combinational so the writer sees it in the request cycle.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant   = 1'b0;
    push       = 1'b0;
    if (rst || start) begin
      wr_state_d = W_IDLE;
    end else begin
      case (wr_state_q)
        W_IDLE: if (wr_req && !full) begin
          wr_grant   = 1'b1;
          wr_state_d = W_FILL;
        end
        W_FILL: if (wr_done) begin
          push       = 1'b1;
          wr_state_d = W_IDLE;
        end
        default: wr_state_d = W_IDLE;
      endcase
    end
  end

  // Read side: a bank under read stays counted until a non-aborted rd_done.
  always_comb begin
    rd_state_d   = rd_state_q;
    gap_d        = gap_q;
    rd_bank_id_d = rd_bank_id_q;
    pop          = 1'b0;
    if (start) begin
      rd_state_d   = R_IDLE;
      gap_d        = 1'b0;
      rd_bank_id_d = '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (!empty) begin
          rd_state_d   = R_PREP;
          rd_bank_id_d = rp;
        end
        R_PREP: if (rd_done) begin
          rd_state_d = R_GAP;
          gap_d      = 1'b0;
          pop        = !pull_back;
        end
        R_GAP: begin
          if (gap_q) rd_state_d = R_IDLE;
          gap_d = 1'b1;
        end
        default: rd_state_d = R_IDLE;
      endcase
    end
    rd_prepare_d = (rd_state_d == R_PREP);
  end

  // A zero cyc_num is treated as one read per layer.
  assign last_cyc  = (cyc_num == '0) ? '0 : cyc_num - CYC_BITWIDTH'(1);
  assign last_read = (cyc_q == last_cyc);

  always_comb begin
    cyc_d      = cyc_q;
    all_done_d = 1'b0;
    if (start) begin
      cyc_d = '0;
    end else if (pop) begin
      all_done_d = last_read;
      cyc_d      = last_read ? '0 : cyc_q + CYC_BITWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q   <= W_IDLE;
      rd_state_q   <= R_IDLE;
      gap_q        <= 1'b0;
      rd_bank_id_q <= '0;
      rd_prepare_q <= 1'b0;
      cyc_q        <= '0;
      all_done_q   <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      gap_q        <= gap_d;
      rd_bank_id_q <= rd_bank_id_d;
      rd_prepare_q <= rd_prepare_d;
      cyc_q        <= cyc_d;
      all_done_q   <= all_done_d;
    end
  end

  assign wr_bank_id = wp;
  assign rd_prepare = rd_prepare_q;
  assign rd_bank_id = rd_bank_id_q;
  assign cyc        = cyc_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_gb_bank_scheduler.sv
// Directed bench for gb_bank_scheduler with hand-computed expectations.
module tb_gb_bank_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, wr_req, wr_done, rd_done, pull_back;
  logic [7:0] cyc_num;
  logic       wr_grant, rd_prepare, all_done;
  logic [1:0] wr_bank_id, rd_bank_id;
  logic [2:0] full_cnt;
  logic [7:0] cyc;

  int n_chk  = 0;
  int n_fail = 0;

  gb_bank_scheduler #(.NUM_BANK(4), .ID_W(2), .CYC_BITWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cyc_num    (cyc_num),
    .wr_req     (wr_req),
    .wr_grant   (wr_grant),
    .wr_bank_id (wr_bank_id),
    .wr_done    (wr_done),
    .rd_prepare (rd_prepare),
    .rd_bank_id (rd_bank_id),
    .rd_done    (rd_done),
    .pull_back  (pull_back),
    .full_cnt   (full_cnt),
    .cyc        (cyc),
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input string tag, input int exp_id);
    wr_req = 1'b1;
    #1;
    check({tag, "_grant"}, wr_grant, 1);
    check({tag, "_wid"}, wr_bank_id, exp_id);
    step();
    wr_req  = 1'b0;
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  task automatic wait_prep(input string tag, input int exp_id);
    int n;
    n = 0;
    while (rd_prepare !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_prep"}, rd_prepare, 1);
    check({tag, "_rid"}, rd_bank_id, exp_id);
  endtask

  task automatic retire(input logic pb);
    rd_done   = 1'b1;
    pull_back = pb;
    step();
    rd_done   = 1'b0;
    pull_back = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_req = 1'b0; wr_done = 1'b0;
    rd_done = 1'b0; pull_back = 1'b0; cyc_num = 8'd2;
    step(); step();
    rst = 1'b0;
    check("rst_prep", rd_prepare, 0);
    check("rst_full", full_cnt, 0);
    check("rst_cyc", cyc, 0);
    check("rst_grant", wr_grant, 0);
    check("rst_alldone", all_done, 0);
    check("rst_wid", wr_bank_id, 0);
    check("rst_rid", rd_bank_id, 0);

    // Fill then read: wr_done three cycles after grant, prepare two cycles after wr_done
    wr_req = 1'b1;
    #1;
    check("t1_grant", wr_grant, 1);
    check("t1_wid", wr_bank_id, 0);
    step();
    wr_req = 1'b0;
    check("t1_grant_low", wr_grant, 0);
    step(); step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("t1_full1", full_cnt, 1);
    check("t1_prep_early", rd_prepare, 0);
    step();
    check("t1_prep", rd_prepare, 1);
    check("t1_rid", rd_bank_id, 0);
    retire(1'b0);
    check("t1_cyc", cyc, 1);
    check("t1_full0", full_cnt, 0);
    check("t1_prep_drop", rd_prepare, 0);
    check("t1_alldone", all_done, 0);
    step(); step(); step(); step();
    check("t1_empty_wait", rd_prepare, 0);

    // Backpressure at full
    do_start();
    check("t2_start_cyc", cyc, 0);
    fill("t2_f0", 0);
    fill("t2_f1", 1);
    fill("t2_f2", 2);
    fill("t2_f3", 3);
    check("t2_full4", full_cnt, 4);
    wr_req = 1'b1;
    #1;
    check("t2_nogrant0", wr_grant, 0);
    step();
    check("t2_nogrant1", wr_grant, 0);
    check("t2_prep", rd_prepare, 1);
    check("t2_rid", rd_bank_id, 0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("t2_full3", full_cnt, 3);
    check("t2_grant_after", wr_grant, 1);
    check("t2_wid_after", wr_bank_id, 0);
    check("t2_cyc", cyc, 1);
    step();
    wr_req  = 1'b0;
    wr_done = 1'b1;
    check("t2_gap1", rd_prepare, 0);
    step();
    wr_done = 1'b0;
    check("t2_full4b", full_cnt, 4);
    check("t2_gap2", rd_prepare, 0);
    step();
    check("t2_rearm", rd_prepare, 1);
    check("t2_rid1", rd_bank_id, 1);

    // Abort on bank 1
    retire(1'b1);
    check("t3_full", full_cnt, 4);
    check("t3_cyc", cyc, 1);
    check("t3_low1", rd_prepare, 0);
    step();
    check("t3_low2", rd_prepare, 0);
    step();
    check("t3_low3", rd_prepare, 0);
    step();
    check("t3_rearm", rd_prepare, 1);
    check("t3_rid", rd_bank_id, 1);
    // Second retire of the layer with cyc_num=2 completes it
    retire(1'b0);
    check("t3_alldone", all_done, 1);
    check("t3_cyc_wrap", cyc, 0);
    check("t3_full3", full_cnt, 3);
    step();
    check("t3_alldone_pulse", all_done, 0);

    // Simultaneous wr_done and normal rd_done at full_cnt=2
    do_start();
    fill("t4_f0", 0);
    fill("t4_f1", 1);
    check("t4_full2", full_cnt, 2);
    wait_prep("t4_r0", 0);
    wr_req = 1'b1;
    #1;
    check("t4_grant", wr_grant, 1);
    check("t4_wid", wr_bank_id, 2);
    step();
    wr_req  = 1'b0;
    wr_done = 1'b1;
    rd_done = 1'b1;
    step();
    wr_done = 1'b0;
    rd_done = 1'b0;
    check("t4_full_same", full_cnt, 2);
    check("t4_wp_adv", wr_bank_id, 3);
    check("t4_cyc", cyc, 1);
    wait_prep("t4_r1", 1);

    // Layer end with cyc_num=3, then cyc_num=0
    do_start();
    cyc_num = 8'd3;
    fill("t5_f0", 0);
    fill("t5_f1", 1);
    fill("t5_f2", 2);
    for (int k = 0; k < 3; k++) begin
      wait_prep("t5_r", k);
      retire(1'b0);
      check("t5_cyc", cyc, (k + 1) % 3);
      check("t5_alldone", all_done, (k == 2) ? 1 : 0);
    end
    step();
    check("t5_alldone_pulse", all_done, 0);
    check("t5_empty", full_cnt, 0);
    cyc_num = 8'd0;
    fill("t5_z0", 3);
    wait_prep("t5_zr0", 3);
    retire(1'b0);
    check("t5_z_alldone0", all_done, 1);
    check("t5_z_cyc0", cyc, 0);
    fill("t5_z1", 0);
    wait_prep("t5_zr1", 0);
    retire(1'b0);
    check("t5_z_alldone1", all_done, 1);
    check("t5_z_cyc1", cyc, 0);

    // Start mid-read
    cyc_num = 8'd2;
    do_start();
    fill("t6_f0", 0);
    fill("t6_f1", 1);
    fill("t6_f2", 2);
    check("t6_full3", full_cnt, 3);
    wait_prep("t6_r0", 0);
    do_start();
    check("t6_prep_clr", rd_prepare, 0);
    check("t6_full_clr", full_cnt, 0);
    check("t6_wp_clr", wr_bank_id, 0);
    check("t6_rid_clr", rd_bank_id, 0);
    check("t6_cyc_clr", cyc, 0);
    retire(1'b0);
    check("t6_stale_full", full_cnt, 0);
    check("t6_stale_cyc", cyc, 0);
    check("t6_stale_prep", rd_prepare, 0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("t6_idle_wrdone", full_cnt, 0);
    fill("t6_nf", 0);
    wait_prep("t6_nr", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
